// File: rtl/nap_eth_tx_pkt_gen.sv
// Ethernet NAP transmit-stream packet generator: emits a programmed run of
// back-to-back packets with a deterministic byte pattern under ready backpressure.
module nap_eth_tx_pkt_gen #(
    parameter int                    DATA_WIDTH = 256,
    parameter int                    MOD_WIDTH  = 5,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] DEST_ADDR  = 4'hf,
    parameter int                    LEN_WIDTH  = 14
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [15:0]           i_num_pkts,
    input  logic [LEN_WIDTH-1:0]  i_pkt_len,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic [MOD_WIDTH-1:0]  o_mod,
    output logic [29:0]           o_timestamp,
    output logic [29:0]           o_flags,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [15:0]           o_pkt_count
);

    localparam int LANES  = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(LANES);
    localparam int BEAT_W = LEN_WIDTH - LANE_W;

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state;
    logic [15:0]          num_pkts_q;
    logic [15:0]          seq;
    logic [LEN_WIDTH-1:0] len_q;
    logic [BEAT_W-1:0]    beat;
    logic [BEAT_W-1:0]    last_beat;
    logic [29:0]          ts_cnt;

    logic                 start_ok;
    logic                 accept;
    logic                 run_end;
    logic                 load;
    logic [15:0]          nxt_seq;
    logic [BEAT_W-1:0]    nxt_beat;
    logic [BEAT_W-1:0]    nxt_last;
    logic [LEN_WIDTH-1:0] nxt_len;
    logic                 nxt_eop;
    logic [29:0]          nxt_flags;

    function automatic logic [BEAT_W-1:0] last_beat_of(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH-1:0] len_m1;
        len_m1 = len - LEN_WIDTH'(1);
        return BEAT_W'(len_m1 >> LANE_W);
    endfunction

    // Byte k of a packet is seq+k; lanes past the packet length are zero.
    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [7:0]           seq8,
                                                        input logic [BEAT_W-1:0]    b,
                                                        input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH-1:0] k;
        beat_data = '0;
        for (int j = 0; j < LANES; j++) begin
            k = {b, j[LANE_W-1:0]};
            if (k < len)
                beat_data[j*8 +: 8] = seq8 + k[7:0];
        end
    endfunction

    assign o_addr = DEST_ADDR;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        start_ok = (state == IDLE) && i_start && (i_num_pkts != '0) && (i_pkt_len != '0);
        accept   = (state == SEND) && i_ready;
        run_end  = accept && o_eop && ((o_pkt_count + 16'd1) == num_pkts_q);
        load     = start_ok || (accept && !run_end);

        nxt_seq  = seq;
        nxt_beat = beat + BEAT_W'(1);
        nxt_len  = len_q;
        nxt_last = last_beat;
        if (state == IDLE) begin
            nxt_seq  = '0;
            nxt_beat = '0;
            nxt_len  = i_pkt_len;
            nxt_last = last_beat_of(i_pkt_len);
        end else if (o_eop) begin
            nxt_seq  = seq + 16'd1;
            nxt_beat = '0;
        end
        nxt_eop   = (nxt_beat == nxt_last);
        nxt_flags = {14'd0, nxt_seq};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            num_pkts_q  <= '0;
            len_q       <= '0;
            seq         <= '0;
            beat        <= '0;
            last_beat   <= '0;
            ts_cnt      <= '0;
            o_valid     <= 1'b0;
            o_sop       <= 1'b0;
            o_eop       <= 1'b0;
            o_mod       <= '0;
            o_data      <= '0;
            o_timestamp <= '0;
            o_flags     <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pkt_count <= '0;
        end else begin
            ts_cnt <= ts_cnt + 30'd1;
            o_done <= 1'b0;

            if (state == IDLE && i_start) begin
                num_pkts_q  <= i_num_pkts;
                len_q       <= i_pkt_len;
                seq         <= '0;
                o_pkt_count <= '0;
                o_done      <= !start_ok;
            end

            if (accept && o_eop)
                o_pkt_count <= o_pkt_count + 16'd1;

            if (load) begin
                state       <= SEND;
                o_valid     <= 1'b1;
                o_busy      <= 1'b1;
                seq         <= nxt_seq;
                beat        <= nxt_beat;
                last_beat   <= nxt_last;
                o_sop       <= (nxt_beat == '0);
                o_eop       <= nxt_eop;
                o_mod       <= nxt_eop ? MOD_WIDTH'(nxt_len[LANE_W-1:0]) : '0;
                o_data      <= beat_data(nxt_seq[7:0], nxt_beat, nxt_len);
                o_flags     <= nxt_flags;
                // ts_cnt+1 is the counter value during the cycle this sop is shown.
                o_timestamp <= (nxt_beat == '0) ? ts_cnt + 30'd1 : nxt_flags;
            end else if (run_end) begin
                state       <= IDLE;
                o_valid     <= 1'b0;
                o_busy      <= 1'b0;
                o_done      <= 1'b1;
                o_sop       <= 1'b0;
                o_eop       <= 1'b0;
                o_mod       <= '0;
                o_data      <= '0;
                o_timestamp <= '0;
                o_flags     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_nap_eth_tx_pkt_gen.sv
// Self-checking bench for nap_eth_tx_pkt_gen: table of runs, random runs, and
// hand-written start-ignore and mid-packet reset sequences against a byte-level model.
module tb_nap_eth_tx_pkt_gen;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_start;
    logic [15:0]  i_num_pkts;
    logic [13:0]  i_pkt_len;
    logic [3:0]   o_addr;
    logic         o_valid;
    logic         i_ready;
    logic [255:0] o_data;
    logic         o_sop;
    logic         o_eop;
    logic [4:0]   o_mod;
    logic [29:0]  o_timestamp;
    logic [29:0]  o_flags;
    logic         o_busy;
    logic         o_done;
    logic [15:0]  o_pkt_count;

    int n_vec = 0;
    int n_err = 0;

    nap_eth_tx_pkt_gen dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_num_pkts  (i_num_pkts),
        .i_pkt_len   (i_pkt_len),
        .o_addr      (o_addr),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_sop       (o_sop),
        .o_eop       (o_eop),
        .o_mod       (o_mod),
        .o_timestamp (o_timestamp),
        .o_flags     (o_flags),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pkt_count (o_pkt_count)
    );

    always #5 i_clk = ~i_clk;

    // Reference cycle counter: cleared by reset, +1 on every clock edge.
    logic [29:0] tb_cnt;
    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) tb_cnt <= '0;
        else         tb_cnt <= tb_cnt + 30'd1;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected bytes of beat b of packet p: byte k = (p + k) mod 256 while k < len.
    function automatic logic [255:0] model_beat(input int p, input int b, input int len);
        logic [255:0] d;
        int k;
        d = '0;
        for (int j = 0; j < 32; j++) begin
            k = b * 32 + j;
            if (k < len) d[j*8 +: 8] = 8'((p + k) % 256);
        end
        return d;
    endfunction

    function automatic logic pick(input int pct);
        return ($urandom_range(99, 0) < pct);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_sop"},   o_sop, 0);
        check({tag, "_eop"},   o_eop, 0);
        check({tag, "_mod"},   o_mod, 0);
        check({tag, "_data"},  o_data, 0);
        check({tag, "_ts"},    o_timestamp, 0);
        check({tag, "_flags"}, o_flags, 0);
        check({tag, "_busy"},  o_busy, 0);
        check({tag, "_done"},  o_done, 0);
        check({tag, "_cnt"},   o_pkt_count, 0);
        check({tag, "_addr"},  o_addr, 4'hf);
    endtask

    // One run from the start pulse through the done pulse, checked beat by beat.
    task automatic do_run(input int num, input int len, input int ready_pct, input bit poke,
                          output int beats_seen, output int last_mod);
        int p, b, nb, cyc, sop_ts, exp_flags;
        bit stalled;
        logic [255:0] prev_d;
        beats_seen = 0;
        last_mod   = -1;
        @(negedge i_clk);
        i_start    = 1'b1;
        i_num_pkts = 16'(num);
        i_pkt_len  = 14'(len);
        i_ready    = pick(ready_pct);
        @(negedge i_clk);
        i_start    = 1'b0;
        i_num_pkts = 16'($urandom);
        i_pkt_len  = 14'($urandom);
        if (num == 0 || len == 0) begin
            check("zero_done",  o_done, 1);
            check("zero_valid", o_valid, 0);
            check("zero_busy",  o_busy, 0);
            @(negedge i_clk);
            check("zero_done_clr", o_done, 0);
            check("zero_valid2",   o_valid, 0);
            return;
        end
        nb = (len + 31) / 32;
        p = 0; b = 0; cyc = 0; stalled = 0; sop_ts = 0; prev_d = '0;
        while (p < num && cyc < 4000) begin
            if (!stalled && b == 0) sop_ts = int'(tb_cnt);
            exp_flags = p & 32'h1ffff;
            check("valid", o_valid, 1);
            check("busy",  o_busy, 1);
            check("done",  o_done, 0);
            check("pkt_count", o_pkt_count, p);
            check("data",  o_data, model_beat(p, b, len));
            check("sop",   o_sop, b == 0);
            check("eop",   o_eop, b == nb - 1);
            check("mod",   o_mod, (b == nb - 1) ? len % 32 : 0);
            check("flags", o_flags, exp_flags);
            check("timestamp", o_timestamp, (b == 0) ? sop_ts : exp_flags);
            if (stalled) check("stall_hold", o_data, prev_d);
            prev_d = o_data;
            i_start = (poke && cyc == 1);
            if (i_start) begin
                i_num_pkts = 16'd9;
                i_pkt_len  = 14'd3;
            end
            i_ready = pick(ready_pct);
            @(negedge i_clk);
            cyc++;
            i_start = 1'b0;
            if (i_ready) begin
                beats_seen++;
                stalled = 0;
                if (b == nb - 1) begin
                    last_mod = len % 32;
                    b = 0;
                    p++;
                end else begin
                    b++;
                end
            end else begin
                stalled = 1;
            end
        end
        check("run_complete", p, num);
        check("end_done",  o_done, 1);
        check("end_busy",  o_busy, 0);
        check("end_valid", o_valid, 0);
        check("end_count", o_pkt_count, num);
        if (ready_pct >= 100) check("no_gaps", cyc, num * nb);
        @(negedge i_clk);
        check("done_one_cycle", o_done, 0);
        check("count_held", o_pkt_count, num);
    endtask

    typedef struct {
        int num;
        int len;
        int ready_pct;
        bit poke;
        int exp_beats;
        int exp_mod;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, lmod, num, len, pct;

        vecs[0] = '{1,  64, 100, 1'b0,  2,  0};
        vecs[1] = '{2,  65, 100, 1'b0,  6,  1};
        vecs[2] = '{3,   1, 100, 1'b0,  3,  1};
        vecs[3] = '{4, 100,  50, 1'b0, 16,  4};
        vecs[4] = '{0,  10, 100, 1'b0,  0, -1};
        vecs[5] = '{3,   0, 100, 1'b0,  0, -1};
        vecs[6] = '{2,  64, 100, 1'b1,  4,  0};
        vecs[7] = '{2,  33,  30, 1'b0,  4,  1};
        vecs[8] = '{1,  32, 100, 1'b0,  1,  0};

        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_num_pkts = '0;
        i_pkt_len  = '0;
        i_ready    = 1'b0;
        #23;
        check_idle_outputs("rst");
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        check_idle_outputs("post_rst");

        foreach (vecs[i]) begin
            do_run(vecs[i].num, vecs[i].len, vecs[i].ready_pct, vecs[i].poke, beats, lmod);
            check($sformatf("vec%0d_beats", i), beats, vecs[i].exp_beats);
            check($sformatf("vec%0d_last_mod", i), lmod, vecs[i].exp_mod);
        end

        for (int r = 0; r < 6; r++) begin
            num = $urandom_range(5, 1);
            len = $urandom_range(300, 1);
            pct = $urandom_range(100, 20);
            do_run(num, len, pct, 1'b0, beats, lmod);
            check($sformatf("rand%0d_beats", r), beats, num * ((len + 31) / 32));
            check($sformatf("rand%0d_last_mod", r), lmod, len % 32);
        end

        // Reset while the third beat of a 128-byte packet is on the bus.
        @(negedge i_clk);
        i_start = 1'b1; i_num_pkts = 16'd1; i_pkt_len = 14'd128; i_ready = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        check("mid_beat2_byte0", o_data[7:0], 8'h40);
        check("mid_beat2_valid", o_valid, 1);
        #2 i_reset = 1'b1;
        #1;
        check_idle_outputs("mid_rst");
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        check_idle_outputs("mid_rst_rel");
        do_run(2, 40, 100, 1'b0, beats, lmod);
        check("restart_beats", beats, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
